// File: rtl/riscv_pkg.sv
// Shared definitions for the core pipeline: writeback source select,
// load funct3 encodings and the MEM/WB stage state encoding.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_wb_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> MEM/WB handshake plus the data-memory response channel.
//   master : MEM stage / data memory side (drives instruction fields and response)
//   slave  : MEM/WB stage (drives in_ready)
// Signals:
//   in_valid, in_ready          instruction handshake
//   in_reg_write, in_rd         destination register and write enable
//   in_wb_sel, in_funct3        writeback source, load type
//   in_alu_result, in_pc_plus4  ALU result / load address, link value
//   mem_rsp_valid, mem_rsp_data load response from data memory
interface mem_wb_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [1:0]            in_wb_sel;
  logic [2:0]            in_funct3;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_pc_plus4;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_data;

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, mem_rsp_valid, mem_rsp_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, mem_rsp_valid, mem_rsp_data,
    output in_ready
  );
endinterface

// File: rtl/load_formatter.sv
// Combinational load data formatter: selects byte/halfword from an aligned
// memory word by address offset and sign- or zero-extends it.
// Ports:
//   funct3  load type (LB/LH/LW/LBU/LHU; other codes behave as LW)
//   off     low address bits of the load
//   raw     aligned word returned by data memory
//   data    formatted XLEN result
module load_formatter
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase

    // Misaligned halfwords only look at off[1]; trapping is the MEM stage's job.
    half_sel = off[1] ? raw[31:16] : raw[15:0];

    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage. Accepts retiring instructions, waits for the
// data-memory response on loads, formats load data and drives the
// register-file write port (also used by EX-stage forwarding).
// Ports:
//   clk, reset     core clock, async active-high reset
//   bus            slave side of mem_wb_stage_if (handshake + memory response)
//   RegWrite       one-cycle register-file write pulse
//   writeReg       register-file write address (holds when not writing)
//   writeData      register-file write data (holds when not writing)
//   load_pending   high while a load waits for its response
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_wb_stage_if.slave         bus,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [XLEN-1:0]       writeData,
  output logic                  load_pending
);

  mem_wb_state_e         state;
  logic                  cap_reg_write;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic [2:0]            cap_funct3;
  logic [1:0]            cap_off;
  logic [XLEN-1:0]       load_data;
  logic                  is_load;

  assign bus.in_ready = (state == IDLE);
  assign load_pending = (state == WAIT_RSP);
  assign is_load      = (bus.in_wb_sel == WB_LOAD);

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .funct3 (cap_funct3),
    .off    (cap_off),
    .raw    (bus.mem_rsp_data),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      RegWrite      <= 1'b0;
      writeReg      <= '0;
      writeData     <= '0;
      cap_reg_write <= 1'b0;
      cap_rd        <= '0;
      cap_funct3    <= '0;
      cap_off       <= '0;
    end else begin
      RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_load) begin
              cap_reg_write <= bus.in_reg_write;
              cap_rd        <= bus.in_rd;
              cap_funct3    <= bus.in_funct3;
              cap_off       <= bus.in_alu_result[1:0];
              state         <= WAIT_RSP;
            end else if (bus.in_reg_write && (bus.in_rd != '0)) begin
              // Reserved wb_sel 11 falls through to the ALU result.
              RegWrite  <= 1'b1;
              writeReg  <= bus.in_rd;
              writeData <= (bus.in_wb_sel == WB_PC4) ? bus.in_pc_plus4
                                                     : bus.in_alu_result;
            end
          end
        end
        WAIT_RSP: begin
          if (bus.mem_rsp_valid) begin
            state <= IDLE;
            if (cap_reg_write && (cap_rd != '0)) begin
              RegWrite  <= 1'b1;
              writeReg  <= cap_rd;
              writeData <= load_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        load_pending;

  int vectors     = 0;
  int miscompares = 0;
  exp_t sb[$];

  mem_wb_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .RegWrite     (RegWrite),
    .writeReg     (writeReg),
    .writeData    (writeData),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b0 && RegWrite === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, none expected", writeReg, writeData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (writeReg !== e.rd || writeData !== e.data) begin
          miscompares++;
          $display("FAIL write_port: got rd=%0d data=%h, expected rd=%0d data=%h",
                   writeReg, writeData, e.rd, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * off)) & 32'h0000_00FF;
    h = (raw >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return raw;
    endcase
  endfunction

  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    bus.in_valid      = 1'b1;
    bus.in_reg_write  = rw;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_funct3     = f3;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++;
    if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0 ||
        load_pending !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got we=%b rd=%0d data=%h pend=%b rdy=%b, expected 0 0 0 0 1",
               RegWrite, writeReg, writeData, load_pending, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    sb.push_back('{rd: 5'd5, data: 32'h0000_1234});
    send(1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0);
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL alu_latency: %0d writes outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    vectors++;
    if (RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_pulse: got RegWrite=%b second cycle, expected 0", RegWrite);
    end
  endtask

  task automatic test_lb_sign();
    @(negedge clk);
    send(1'b1, 5'd7, 2'b01, 3'b000, 32'h0000_1003, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b0 || load_pending !== 1'b1 || RegWrite !== 1'b0) begin
        miscompares++;
        $display("FAIL lb_wait: cycle %0d got rdy=%b pend=%b we=%b, expected 0 1 0",
                 i, bus.in_ready, load_pending, RegWrite);
      end
    end
    sb.push_back('{rd: 5'd7, data: 32'hFFFF_FF80});
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h80FF_0000;
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0 || bus.in_ready !== 1'b1 || load_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL lb_done: outstanding=%0d rdy=%b pend=%b, expected 0 1 0",
               sb.size(), bus.in_ready, load_pending);
    end
  endtask

  task automatic test_load_formats();
    logic [2:0]  f3_t  [9] = '{3'b101, 3'b001, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b101};
    logic [31:0] alu_t [9] = '{32'h2002, 32'h2002, 32'h2003, 32'h2001, 32'h2003, 32'h2002, 32'h2001, 32'h2000, 32'h2001};
    logic [31:0] raw_t [9] = '{32'hBEEF_0001, 32'hBEEF_0001, 32'h7A12_3456, 32'h1234_8000,
                               32'h9ABC_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8765_4321, 32'h0000_8001};
    logic [31:0] exp_d;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      // Response in the accept cycle itself must be ignored.
      bus.mem_rsp_valid = (i == 0);
      bus.mem_rsp_data  = 32'h0BAD_0BAD;
      send(1'b1, 5'(10 + i), 2'b01, f3_t[i], alu_t[i], 32'h0);
      bus.mem_rsp_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (load_pending !== 1'b1 || RegWrite !== 1'b0) begin
        miscompares++;
        $display("FAIL fmt_wait[%0d]: got pend=%b we=%b, expected 1 0", i, load_pending, RegWrite);
      end
      exp_d = model_load(f3_t[i], alu_t[i][1:0], raw_t[i]);
      sb.push_back('{rd: 5'(10 + i), data: exp_d});
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = raw_t[i];
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0 || load_pending !== 1'b0) begin
        miscompares++;
        $display("FAIL fmt_done[%0d]: outstanding=%0d pend=%b, expected 0 0", i, sb.size(), load_pending);
      end
    end
    // Load to x0 still waits for its response but never writes.
    @(negedge clk);
    send(1'b1, 5'd0, 2'b01, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (load_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_load_wait: got pend=%b, expected 1", load_pending);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (RegWrite !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_load_done: got we=%b rdy=%b, expected 0 1", RegWrite, bus.in_ready);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    send(1'b1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0000_0100);
    @(negedge clk);
    vectors++;
    if (RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_jal: got RegWrite=%b, expected 0", RegWrite);
    end
    sb.push_back('{rd: 5'd1, data: 32'h0000_0104});
    send(1'b1, 5'd1, 2'b10, 3'b000, 32'hFFFF_0000, 32'h0000_0104);
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL jal_link: %0d writes outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rd_t  [3] = '{5'd3, 5'd4, 5'd31};
    logic [1:0]  sel_t [3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] alu_t [3] = '{32'hA5A5_0001, 32'h1111_1111, 32'h0F0F_0F0F};
    logic [31:0] pc_t  [3] = '{32'h0, 32'h0000_2008, 32'h3333_3333};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, bus.in_ready);
      end
      sb.push_back('{rd: rd_t[i], data: (sel_t[i] == 2'b10) ? pc_t[i] : alu_t[i]});
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_rd         = rd_t[i];
      bus.in_wb_sel     = sel_t[i];
      bus.in_funct3     = 3'b000;
      bus.in_alu_result = alu_t[i];
      bus.in_pc_plus4   = pc_t[i];
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_writes: %0d writes outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    send(1'b1, 5'd9, 2'b01, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    vectors++;
    if (load_pending !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_state: got pend=%b rdy=%b, expected 0 1", load_pending, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (RegWrite !== 1'b0 || bus.in_ready !== 1'b1 || load_pending !== 1'b0 ||
        writeReg !== 5'd0 || writeData !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_rsp: got we=%b rdy=%b pend=%b rd=%0d data=%h, expected 0 1 0 0 0",
               RegWrite, bus.in_ready, load_pending, writeReg, writeData);
    end
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_rd         = '0;
    bus.in_wb_sel     = '0;
    bus.in_funct3     = '0;
    bus.in_alu_result = '0;
    bus.in_pc_plus4   = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    test_reset();
    test_alu();
    test_lb_sign();
    test_load_formats();
    test_x0();
    test_back_to_back();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d writes never seen, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
